// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Package : seq_pkg
// Brief   : Opcode and state encodings plus instruction field widths for the
//           instruction sequencer.
// Rev     : 1.0  initial release
// ============================================================================
package seq_pkg;

  localparam int c_opc_w   = 4;
  localparam int c_reg_w   = 2;
  localparam int c_imm_w   = 8;
  localparam int c_instr_w = c_opc_w + 2 * c_reg_w + c_imm_w;

  typedef enum logic [c_opc_w-1:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_SHL  = 4'd2,  OP_SHR  = 4'd3,
    OP_CMP  = 4'd4,  OP_AND  = 4'd5,  OP_OR   = 4'd6,  OP_XOR  = 4'd7,
    OP_NAND = 4'd8,  OP_NOR  = 4'd9,  OP_XNOR = 4'd10, OP_INV  = 4'd11,
    OP_NEG  = 4'd12, OP_STO  = 4'd13, OP_SWP  = 4'd14, OP_LOAD = 4'd15
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_SWP2 = 2'd2,
    S_MEM  = 2'd3
  } state_t;

  // Opcodes whose result comes back from the external ALU and lands in R[rd]
  function automatic logic is_alu_op(input opcode_t op);
    return !(op inside {OP_CMP, OP_STO, OP_SWP, OP_LOAD});
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface : instr_sequencer_if
// Brief     : Instruction, ALU and memory channels of the sequencer.
// Rev       : 1.0  initial release
// ============================================================================
interface instr_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              instr_valid;
  logic              instr_ready;
  logic [15:0]       instr;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              mem_req;
  logic              mem_we;
  logic [7:0]        mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  instr_valid, instr, alu_result, mem_ack, mem_rdata,
    output instr_ready, alu_op, alu_a, alu_b, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output instr_valid, instr, alu_result, mem_ack, mem_rdata,
    input  instr_ready, alu_op, alu_a, alu_b, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/seq_regfile.sv
`default_nettype none
// ============================================================================
// Module : seq_regfile
// Brief  : NREG x DATA_W register file, one write port, two async read ports.
// Rev    : 1.0  initial release
// ============================================================================
module seq_regfile #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    i_we,
  input  wire logic [$clog2(NREG)-1:0] i_waddr,
  input  wire logic [DATA_W-1:0]       i_wdata,
  input  wire logic [$clog2(NREG)-1:0] i_raddr_a,
  input  wire logic [$clog2(NREG)-1:0] i_raddr_b,
  output logic      [DATA_W-1:0]       o_rdata_a,
  output logic      [DATA_W-1:0]       o_rdata_b
);

  logic [DATA_W-1:0] r_mem [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module : instr_sequencer
// Brief  : Fetch-accept / execute / memory sequencer for a 4-register datapath.
//          Optional retire counter enabled by macro SEQ_RETIRE_CNT_EN.
// Rev    : 1.0  initial release
// ============================================================================
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  instr_sequencer_if.master bus,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_c,
  output logic              retire
`ifdef SEQ_RETIRE_CNT_EN
  ,
  output logic [15:0]       retire_cnt
`endif
);

  state_t                 r_state;
  logic [c_instr_w-1:0]   r_instr;
  logic [DATA_W-1:0]      r_tmp;
  logic                   r_mem_req;
  logic                   r_mem_we;
  logic [c_imm_w-1:0]     r_mem_addr;
  logic [DATA_W-1:0]      r_mem_wdata;

  opcode_t                w_op;
  logic [c_reg_w-1:0]     w_rd;
  logic [c_reg_w-1:0]     w_rs;
  logic [DATA_W-1:0]      w_ra;
  logic [DATA_W-1:0]      w_rb;
  logic                   w_exec;
  logic                   w_we;
  logic [c_reg_w-1:0]     w_waddr;
  logic [DATA_W-1:0]      w_wdata;

  assign w_op   = opcode_t'(r_instr[15:12]);
  assign w_rd   = r_instr[11:10];
  assign w_rs   = r_instr[9:8];
  assign w_exec = (r_state == S_EXEC);

  seq_regfile #(.DATA_W(DATA_W), .NREG(NREG)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_rd),
    .i_raddr_b (w_rs),
    .o_rdata_a (w_ra),
    .o_rdata_b (w_rb)
  );

  // Ready is gated by rst so it reads 0 for the whole reset assertion
  assign bus.instr_ready = (r_state == S_IDLE) & ~rst;
  assign bus.alu_op      = w_exec ? r_instr[15:12] : 4'd0;
  assign bus.alu_a       = w_exec ? w_ra : '0;
  assign bus.alu_b       = w_exec ? w_rb : '0;
  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;

  always_comb begin
    w_we    = 1'b0;
    w_waddr = w_rd;
    w_wdata = bus.alu_result;
    case (r_state)
      S_EXEC: begin
        if (is_alu_op(w_op)) begin
          w_we = 1'b1;
        end else if (w_op == OP_SWP) begin
          w_we    = 1'b1;
          w_wdata = w_rb;
        end
      end
      S_SWP2: begin
        w_we    = 1'b1;
        w_waddr = w_rs;
        w_wdata = r_tmp;
      end
      S_MEM: begin
        w_we    = bus.mem_ack & ~r_mem_we;
        w_wdata = bus.mem_rdata;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_instr     <= '0;
      r_tmp       <= '0;
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
      flag_c      <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      retire      <= 1'b0;
    end else begin
      retire <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.instr_valid && bus.instr_ready) begin
            r_instr <= bus.instr;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (w_op)
            OP_CMP: begin
              flag_z  <= (w_ra == w_rb);
              flag_n  <= ($signed(w_ra) < $signed(w_rb));
              flag_c  <= (w_ra < w_rb);
              retire  <= 1'b1;
              r_state <= S_IDLE;
            end
            OP_SWP: begin
              r_tmp   <= w_ra;
              r_state <= S_SWP2;
            end
            OP_STO, OP_LOAD: begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= (w_op == OP_STO);
              r_mem_addr  <= r_instr[7:0];
              r_mem_wdata <= w_rb;
              r_state     <= S_MEM;
            end
            default: begin
              retire  <= 1'b1;
              r_state <= S_IDLE;
            end
          endcase
        end
        S_SWP2: begin
          retire  <= 1'b1;
          r_state <= S_IDLE;
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            retire    <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  logic [15:0] r_retire_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_retire_cnt <= '0;
    else if (retire) r_retire_cnt <= r_retire_cnt + 16'd1;
  end

  assign retire_cnt = r_retire_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_instr_sequencer
// Brief  : Directed self-checking bench for instr_sequencer with an ALU model
//          and a scripted memory responder.
// Rev    : 1.0  initial release
// ============================================================================
module tb_instr_sequencer;
  import seq_pkg::*;

  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst;
  logic flag_z, flag_n, flag_c, retire;
`ifdef SEQ_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  instr_sequencer_if #(.DATA_W(DATA_W)) bus ();

  instr_sequencer #(.DATA_W(DATA_W), .NREG(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .flag_z (flag_z),
    .flag_n (flag_n),
    .flag_c (flag_c),
    .retire (retire)
`ifdef SEQ_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_cnt)
`endif
  );

  // Reference ALU: shifts are by one position
  always_comb begin
    case (bus.alu_op)
      4'd0:    bus.alu_result = bus.alu_a + bus.alu_b;
      4'd1:    bus.alu_result = bus.alu_a - bus.alu_b;
      4'd2:    bus.alu_result = bus.alu_a << 1;
      4'd3:    bus.alu_result = bus.alu_a >> 1;
      4'd5:    bus.alu_result = bus.alu_a & bus.alu_b;
      4'd6:    bus.alu_result = bus.alu_a | bus.alu_b;
      4'd7:    bus.alu_result = bus.alu_a ^ bus.alu_b;
      4'd8:    bus.alu_result = ~(bus.alu_a & bus.alu_b);
      4'd9:    bus.alu_result = ~(bus.alu_a | bus.alu_b);
      4'd10:   bus.alu_result = ~(bus.alu_a ^ bus.alu_b);
      4'd11:   bus.alu_result = ~bus.alu_a;
      4'd12:   bus.alu_result = 8'd0 - bus.alu_a;
      default: bus.alu_result = 8'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // Called on a falling edge; returns on the falling edge after acceptance
  task automatic send(input logic [15:0] w);
    int n = 0;
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    while (!bus.instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_ready) check("accept_timeout", 32'(bus.instr_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
  endtask

  // lat counts cycles since the accepting edge
  task automatic wait_retire(output int lat);
    lat = 1;
    while (!retire && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!retire) check("retire_timeout", 32'(retire), 1);
  endtask

  task automatic mem_service(input int delay, input logic [7:0] exp_addr, input logic exp_we,
                             input logic [7:0] rdata, output logic [7:0] wd);
    int n = 0;
    int lat;
    while (!bus.mem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.mem_req) check("mem_req_timeout", 32'(bus.mem_req), 1);
    check("mem_addr", 32'(bus.mem_addr), 32'(exp_addr));
    check("mem_we", 32'(bus.mem_we), 32'(exp_we));
    wd = bus.mem_wdata;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("mem_req_hold", 32'(bus.mem_req), 1);
      check("mem_addr_hold", 32'(bus.mem_addr), 32'(exp_addr));
      check("mem_wdata_hold", 32'(bus.mem_wdata), 32'(wd));
      check("ready_in_mem", 32'(bus.instr_ready), 0);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = rdata;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("mem_req_drop", 32'(bus.mem_req), 0);
    wait_retire(lat);
  endtask

  task automatic do_load(input logic [1:0] rd, input logic [7:0] imm, input logic [7:0] data);
    logic [7:0] wd;
    send(mk(OP_LOAD, rd, 2'd0, imm));
    mem_service(1, imm, 1'b0, data, wd);
  endtask

  // Registers are observed through the store data path
  task automatic read_reg(input logic [1:0] r, output logic [7:0] v);
    send(mk(OP_STO, 2'd0, r, 8'hEE));
    mem_service(0, 8'hEE, 1'b1, 8'h00, v);
  endtask

  initial begin
    int         lat;
    logic [7:0] v;

    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;

    @(negedge clk);
    check("rst_ready", 32'(bus.instr_ready), 0);
    check("rst_mem_req", 32'(bus.mem_req), 0);
    check("rst_retire", 32'(retire), 0);
    check("rst_flags", {29'd0, flag_z, flag_n, flag_c}, 0);
    check("rst_alu_op", 32'(bus.alu_op), 0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("ready_after_rst", 32'(bus.instr_ready), 1);
    @(negedge clk);

    // LOAD R1/R2 then ADD
    do_load(2'd1, 8'h20, 8'h05);
    do_load(2'd2, 8'h21, 8'h03);
    send(mk(OP_ADD, 2'd1, 2'd2, 8'h00));
    check("add_alu_op", 32'(bus.alu_op), 0);
    check("add_alu_a", 32'(bus.alu_a), 32'h05);
    check("add_alu_b", 32'(bus.alu_b), 32'h03);
    check("add_ready_exec", 32'(bus.instr_ready), 0);
    wait_retire(lat);
    check("add_latency", 32'(lat), 2);
    check("add_ready_back", 32'(bus.instr_ready), 1);
    check("idle_alu_a", 32'(bus.alu_a), 0);
    read_reg(2'd1, v);
    check("add_r1", 32'(v), 32'h08);

    // CMP signed/unsigned disagreement, then equality
    do_load(2'd1, 8'h22, 8'h80);
    do_load(2'd2, 8'h23, 8'h01);
    send(mk(OP_CMP, 2'd1, 2'd2, 8'h00));
    wait_retire(lat);
    check("cmp_latency", 32'(lat), 2);
    check("cmp_flags", {29'd0, flag_z, flag_n, flag_c}, 32'b010);
    read_reg(2'd1, v);
    check("cmp_r1_kept", 32'(v), 32'h80);
    check("flags_kept_sto", {29'd0, flag_z, flag_n, flag_c}, 32'b010);
    send(mk(OP_CMP, 2'd2, 2'd1, 8'h00));
    wait_retire(lat);
    check("cmp_flags_c", {29'd0, flag_z, flag_n, flag_c}, 32'b001);
    send(mk(OP_CMP, 2'd1, 2'd1, 8'h00));
    wait_retire(lat);
    check("cmp_flags_eq", {29'd0, flag_z, flag_n, flag_c}, 32'b100);

    // SWP distinct and same register
    do_load(2'd1, 8'h24, 8'hAA);
    do_load(2'd2, 8'h25, 8'h55);
    send(mk(OP_SWP, 2'd1, 2'd2, 8'h00));
    wait_retire(lat);
    check("swp_latency", 32'(lat), 3);
    read_reg(2'd1, v);
    check("swp_r1", 32'(v), 32'h55);
    read_reg(2'd2, v);
    check("swp_r2", 32'(v), 32'hAA);
    send(mk(OP_SWP, 2'd1, 2'd1, 8'h00));
    wait_retire(lat);
    check("swp_same_latency", 32'(lat), 3);
    read_reg(2'd1, v);
    check("swp_same_r1", 32'(v), 32'h55);

    // STO with a slow memory
    send(mk(OP_STO, 2'd0, 2'd2, 8'h10));
    mem_service(4, 8'h10, 1'b1, 8'h00, v);
    check("sto_wdata", 32'(v), 32'hAA);

    // Stray ack while idle
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    check("stray_ack_retire", 32'(retire), 0);
    check("stray_ack_ready", 32'(bus.instr_ready), 1);

    // Reset during LOAD memory wait
    send(mk(OP_LOAD, 2'd3, 2'd0, 8'h30));
    @(negedge clk);
    check("ld_wait_req", 32'(bus.mem_req), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_mem_req", 32'(bus.mem_req), 0);
    check("abort_ready", 32'(bus.instr_ready), 0);
    check("abort_retire", 32'(retire), 0);
    check("abort_flags", {29'd0, flag_z, flag_n, flag_c}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_abort_retire", 32'(retire), 0);
    end
    read_reg(2'd3, v);
    check("abort_r3", 32'(v), 0);
    read_reg(2'd1, v);
    check("abort_r1", 32'(v), 0);
    do_load(2'd3, 8'h31, 8'h01);
    read_reg(2'd3, v);
    check("reload_r3", 32'(v), 32'h01);

    // Back-to-back NEG then INV with valid held high
    bus.instr_valid = 1'b1;
    bus.instr       = mk(OP_NEG, 2'd3, 2'd0, 8'h00);
    check("b2b_ready0", 32'(bus.instr_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.instr = mk(OP_INV, 2'd3, 2'd0, 8'h00);
    check("neg_alu_op", 32'(bus.alu_op), 32'd12);
    check("neg_alu_a", 32'(bus.alu_a), 32'h01);
    check("neg_ready_exec", 32'(bus.instr_ready), 0);
    @(negedge clk);
    check("neg_retire", 32'(retire), 1);
    check("b2b_ready1", 32'(bus.instr_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.instr_valid = 1'b0;
    check("inv_alu_op", 32'(bus.alu_op), 32'd11);
    check("inv_alu_a", 32'(bus.alu_a), 32'hFF);
    wait_retire(lat);
    check("inv_latency", 32'(lat), 2);
    read_reg(2'd3, v);
    check("inv_r3", 32'(v), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter DATA_W, default 8: register, ALU operand and memory data width.
REQ-002 Parameter NREG, default 4, fixed at 4: number of general registers, R0..R3.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 instr_valid  in  1  instruction word offered.
REQ-006 instr_ready  out  1  sequencer can accept an instruction.
REQ-007 instr  in  16  instruction word: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
REQ-008 alu_op  out  4  operation select to the ALU operation units.
REQ-009 alu_a, alu_b  out  DATA_W  ALU operands: alu_a = R[rd], alu_b = R[rs].
REQ-010 alu_result  in  DATA_W  combinational ALU result.
REQ-011 mem_req, mem_we  out  1  memory request and write enable.
REQ-012 mem_addr  out  8  memory address, equal to imm.
REQ-013 mem_wdata  out  DATA_W  store data.
REQ-014 mem_ack  in  1  memory completion.
REQ-015 mem_rdata  in  DATA_W  load data.
REQ-016 flag_z, flag_n, flag_c  out  1  compare flags.
REQ-017 retire  out  1  one-cycle pulse when an instruction completes.

Function
REQ-018 Opcode map: ADD=0, SUB=1, SHL=2, SHR=3, CMP=4, AND=5, OR=6, XOR=7, NAND=8, NOR=9, XNOR=10, INV=11, NEG=12, STO=13, SWP=14, LOAD=15.
REQ-019 States: IDLE, EXEC, SWP2, MEM.
REQ-020 instr_ready shall be 1 only in IDLE; an instruction is accepted when instr_valid and instr_ready are both 1, and the sequencer latches it and enters EXEC.
REQ-021 EXEC for opcodes 0-3 and 5-12: drive alu_op, alu_a and alu_b; write alu_result to R[rd] at the end of EXEC; pulse retire; return to IDLE. Latency is 2 cycles from accept to the next instr_ready.
REQ-022 CMP writes no register. It sets flag_z = (a==b), flag_n = signed(a)<signed(b), flag_c = unsigned(a)<unsigned(b). Flags change only on CMP.
REQ-023 SWP: EXEC writes R[rd] <= R[rs] and latches tmp <= old R[rd]; SWP2 writes R[rs] <= tmp and pulses retire. When rd==rs, the registers are unchanged and the swap still takes 3 cycles.
REQ-024 STO enters MEM with mem_req=1, mem_we=1, mem_addr=imm and mem_wdata=R[rs].
REQ-025 LOAD enters MEM with mem_req=1, mem_we=0 and mem_addr=imm.
REQ-026 In MEM, all memory outputs hold stable until mem_ack; on mem_ack, LOAD writes mem_rdata to R[rd]; mem_req drops the next cycle, retire pulses, and the state returns to IDLE.
REQ-027 mem_ack outside MEM shall be ignored.
REQ-028 alu_op shall be 0 and alu_a/alu_b shall be 0 outside EXEC.
REQ-029 All results are truncated to DATA_W.

Reset
REQ-030 rst forces, immediately: state IDLE, R0..R3=0, tmp=0, flags=0, mem_req=0, mem_we=0, retire=0.
REQ-031 instr_ready shall be 0 while rst=1.
REQ-032 Reset mid-instruction aborts it: no writeback, no retire.

Configuration
REQ-033 With SEQ_RETIRE_CNT_EN defined: add output retire_cnt (16 bits), reset to 0, incremented on each retire, wrapping 0xFFFF->0.
REQ-034 Without SEQ_RETIRE_CNT_EN: no retire_cnt port and no counter logic.

Structure
REQ-035 Shared package seq_pkg: opcode enum, state enum, instruction-field width constants.
REQ-036 The register file shall be a sub-module seq_regfile: 4xDATA_W, one write port, two async read ports, async reset.

Verification
REQ-037 Load R1=0x05 and R2=0x03 via LOAD, then ADD rd=1 rs=2 -> R1=0x08, retire 2 cycles after accept.
REQ-038 CMP with R1=0x80, R2=0x01 -> flag_z=0, flag_n=1, flag_c=0; R1 unchanged.
REQ-039 SWP rd=1 rs=2 with R1=0xAA, R2=0x55 -> R1=0x55, R2=0xAA, retire on cycle 3; with rd=rs=1 -> R1 unchanged.
REQ-040 STO rs=2 imm=0x10 with mem_ack delayed 4 cycles -> mem_req/mem_addr=0x10/mem_wdata held 4 cycles, instr_ready=0 throughout.
REQ-041 Assert rst during the LOAD MEM wait -> mem_req=0 immediately, R[rd]=0, no retire; the next LOAD completes normally.
REQ-042 Hold instr_valid=1 continuously over back-to-back NEG then INV on R3=0x01 -> R3=0xFF, then R3=0x00.
